pair_dist_engine: RTL and testbench

Hardware responder for the program-2 start/done handshake. It reads 32 signed 16-bit values from byte-wide data memory, finds the minimum and maximum absolute difference over all 496 unordered pairs, writes both results back to data memory, then acknowledges with `done`. It sits beside data memory as an accelerator and owns the memory port while running.

---
 rtl/dist_pkg.sv | 25 ++
 rtl/abs_dist.sv | 27 ++
 rtl/pair_dist_engine.sv | 184 ++++++++++++++++++
 tb/tb_pair_dist_engine.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/dist_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dist_pkg
//  Description : Shared types and constants for the pair-distance engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package dist_pkg;

    localparam int         N_VALS   = 32;
    localparam int         PAIR_CNT = N_VALS * (N_VALS - 1) / 2;
    localparam logic [7:0] MIN_ADDR = 8'd66;
    localparam logic [7:0] MAX_ADDR = 8'd68;

    typedef logic [15:0] word_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CMP   = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } dist_state_t;

endpackage
`default_nettype wire

// File: rtl/abs_dist.sv
`default_nettype none
// ============================================================================
//  Module      : abs_dist
//  Description : Magnitude of the 17-bit difference of two signed 16-bit
//                values. The result always fits in 16 bits unsigned.
//  Revision    : 1.0 - initial release
// ============================================================================
module abs_dist
    import dist_pkg::*;
(
    input  logic signed [15:0] i_a,
    input  logic signed [15:0] i_b,
    output word_t              o_dist
);

    logic signed [16:0] w_diff;
    logic signed [16:0] w_neg;

    // Sign-extend before subtracting so the difference cannot overflow
    always_comb begin
        w_diff = {i_a[15], i_a} - {i_b[15], i_b};
        w_neg  = -w_diff;
        o_dist = w_diff[16] ? w_neg[15:0] : w_diff[15:0];
    end

endmodule
`default_nettype wire

// File: rtl/pair_dist_engine.sv
`default_nettype none
// ============================================================================
//  Module      : pair_dist_engine
//  Description : Loads 32 signed 16-bit operands from byte memory, scans all
//                unordered pairs for min/max absolute difference, writes both
//                results back (high byte first) and raises done.
//  Revision    : 1.0 - initial release
// ============================================================================
module pair_dist_engine
    import dist_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       done,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_rdata,
    output logic       mem_wen,
    output logic [7:0] mem_wdata,
    output logic [4:0] min_j,
    output logic [4:0] min_k,
    output logic [4:0] max_j,
    output logic [4:0] max_k
);

    localparam logic [4:0] c_LAST_IDX = 5'(N_VALS - 1);
    localparam logic [4:0] c_LAST_J   = 5'(N_VALS - 2);
    localparam logic [5:0] c_LAST_BYTE = 6'(2 * N_VALS - 1);

    dist_state_t r_state_q, w_state_d;
    logic [5:0]  r_byte_q,  w_byte_d;
    logic [4:0]  r_j_q,     w_j_d;
    logic [4:0]  r_k_q,     w_k_d;
    word_t       r_min_q,   w_min_d;
    word_t       r_max_q,   w_max_d;
    logic [4:0]  r_min_j_q, w_min_j_d;
    logic [4:0]  r_min_k_q, w_min_k_d;
    logic [4:0]  r_max_j_q, w_max_j_d;
    logic [4:0]  r_max_k_q, w_max_k_d;
    word_t       r_rf_q [N_VALS];
    word_t       w_rf_d [N_VALS];
    word_t       w_dist;

    abs_dist u_abs_dist (
        .i_a    (r_rf_q[r_j_q]),
        .i_b    (r_rf_q[r_k_q]),
        .o_dist (w_dist)
    );

    // Next-state logic: sequencing of load, pair scan, write-back and handshake
    always_comb begin
        w_state_d = r_state_q;
        w_byte_d  = r_byte_q;
        w_j_d     = r_j_q;
        w_k_d     = r_k_q;
        w_min_d   = r_min_q;
        w_max_d   = r_max_q;
        w_min_j_d = r_min_j_q;
        w_min_k_d = r_min_k_q;
        w_max_j_d = r_max_j_q;
        w_max_k_d = r_max_k_q;
        w_rf_d    = r_rf_q;
        case (r_state_q)
            ST_IDLE: begin
                if (!start) begin
                    w_state_d = ST_LOAD;
                    w_byte_d  = 6'd0;
                    w_min_d   = 16'hFFFF;
                    w_max_d   = 16'h0000;
                    // Indices cleared so an all-equal input gives a defined result
                    w_min_j_d = 5'd0;
                    w_min_k_d = 5'd0;
                    w_max_j_d = 5'd0;
                    w_max_k_d = 5'd0;
                end
            end
            ST_LOAD: begin
                if (r_byte_q[0])
                    w_rf_d[r_byte_q[5:1]][7:0]  = mem_rdata;
                else
                    w_rf_d[r_byte_q[5:1]][15:8] = mem_rdata;
                w_byte_d = r_byte_q + 6'd1;
                if (r_byte_q == c_LAST_BYTE) begin
                    w_state_d = ST_CMP;
                    w_j_d     = 5'd0;
                    w_k_d     = 5'd1;
                end
            end
            ST_CMP: begin
                // Strict compares: the earliest pair in scan order keeps ties
                if (w_dist < r_min_q) begin
                    w_min_d   = w_dist;
                    w_min_j_d = r_j_q;
                    w_min_k_d = r_k_q;
                end
                if (w_dist > r_max_q) begin
                    w_max_d   = w_dist;
                    w_max_j_d = r_j_q;
                    w_max_k_d = r_k_q;
                end
                if (r_k_q == c_LAST_IDX) begin
                    if (r_j_q == c_LAST_J) begin
                        w_state_d = ST_WRITE;
                        w_byte_d  = 6'd0;
                    end else begin
                        w_j_d = r_j_q + 5'd1;
                        w_k_d = r_j_q + 5'd2;
                    end
                end else begin
                    w_k_d = r_k_q + 5'd1;
                end
            end
            ST_WRITE: begin
                w_byte_d = r_byte_q + 6'd1;
                if (r_byte_q[1:0] == 2'd3)
                    w_state_d = ST_DONE;
            end
            ST_DONE: begin
                if (start)
                    w_state_d = ST_IDLE;
            end
            default: w_state_d = ST_IDLE;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= ST_IDLE;
            r_byte_q  <= 6'd0;
            r_j_q     <= 5'd0;
            r_k_q     <= 5'd0;
            r_min_q   <= 16'hFFFF;
            r_max_q   <= 16'h0000;
            r_min_j_q <= 5'd0;
            r_min_k_q <= 5'd0;
            r_max_j_q <= 5'd0;
            r_max_k_q <= 5'd0;
            for (int i = 0; i < N_VALS; i++)
                r_rf_q[i] <= 16'h0000;
        end else begin
            r_state_q <= w_state_d;
            r_byte_q  <= w_byte_d;
            r_j_q     <= w_j_d;
            r_k_q     <= w_k_d;
            r_min_q   <= w_min_d;
            r_max_q   <= w_max_d;
            r_min_j_q <= w_min_j_d;
            r_min_k_q <= w_min_k_d;
            r_max_j_q <= w_max_j_d;
            r_max_k_q <= w_max_k_d;
            for (int i = 0; i < N_VALS; i++)
                r_rf_q[i] <= w_rf_d[i];
        end
    end

    // Memory port decoded from registered state only, never from start
    always_comb begin
        mem_addr  = 8'd0;
        mem_wen   = 1'b0;
        mem_wdata = 8'd0;
        case (r_state_q)
            ST_LOAD: mem_addr = {2'b00, r_byte_q};
            ST_WRITE: begin
                mem_wen = 1'b1;
                case (r_byte_q[1:0])
                    2'd0: begin mem_addr = MIN_ADDR;        mem_wdata = r_min_q[15:8]; end
                    2'd1: begin mem_addr = MIN_ADDR + 8'd1; mem_wdata = r_min_q[7:0];  end
                    2'd2: begin mem_addr = MAX_ADDR;        mem_wdata = r_max_q[15:8]; end
                    default: begin mem_addr = MAX_ADDR + 8'd1; mem_wdata = r_max_q[7:0]; end
                endcase
            end
            default: ;
        endcase
    end

    assign done  = (r_state_q == ST_DONE);
    assign min_j = r_min_j_q;
    assign min_k = r_min_k_q;
    assign max_j = r_max_j_q;
    assign max_k = r_max_k_q;

endmodule
`default_nettype wire

// File: tb/tb_pair_dist_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pair_dist_engine
//  Description : Self-checking bench for pair_dist_engine with a byte memory
//                model and an all-pairs reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pair_dist_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       done;
    logic [7:0] mem_addr;
    logic [7:0] mem_rdata;
    logic       mem_wen;
    logic [7:0] mem_wdata;
    logic [4:0] min_j, min_k, max_j, max_k;

    logic [7:0] mem [256];
    int         wr_cnt;
    int         bad_wr;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        logic [31:0][15:0] vals;
        logic [15:0]       mn;
        logic [15:0]       mx;
        logic [4:0]        mnj, mnk, mxj, mxk;
    } vec_t;

    localparam int NVEC = 9;
    vec_t tbl [NVEC];

    always #5 clk = ~clk;

    pair_dist_engine dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_wen   (mem_wen),
        .mem_wdata (mem_wdata),
        .min_j     (min_j),
        .min_k     (min_k),
        .max_j     (max_j),
        .max_k     (max_k)
    );

    assign mem_rdata = mem[mem_addr];

    // Byte memory with write tracking
    always @(posedge clk) begin
        if (mem_wen) begin
            mem[mem_addr] = mem_wdata;
            wr_cnt = wr_cnt + 1;
            if (mem_addr < 8'd66 || mem_addr > 8'd69)
                bad_wr = bad_wr + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: exhaustive pair scan with integer arithmetic, first-found wins
    function automatic void model(input logic [31:0][15:0] v, output logic [15:0] mn,
                                  output logic [15:0] mx, output logic [4:0] mnj,
                                  output logic [4:0] mnk, output logic [4:0] mxj,
                                  output logic [4:0] mxk);
        int best_min = 65535;
        int best_max = 0;
        mnj = 0; mnk = 0; mxj = 0; mxk = 0;
        for (int j = 0; j < 32; j++) begin
            for (int k = j + 1; k < 32; k++) begin
                int d = int'($signed(v[j])) - int'($signed(v[k]));
                if (d < 0) d = -d;
                if (d < best_min) begin best_min = d; mnj = 5'(j); mnk = 5'(k); end
                if (d > best_max) begin best_max = d; mxj = 5'(j); mxk = 5'(k); end
            end
        end
        mn = 16'(best_min);
        mx = 16'(best_max);
    endfunction

    task automatic load_mem(input vec_t tv);
        for (int i = 0; i < 32; i++) begin
            mem[2*i]   = tv.vals[i][15:8];
            mem[2*i+1] = tv.vals[i][7:0];
        end
        for (int a = 64; a < 256; a++) mem[a] = 8'hEE;
        wr_cnt = 0;
        bad_wr = 0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!done && cyc < 2000);
    endtask

    task automatic check_results(input vec_t tv, input string tag);
        check({tag, " min_bytes"}, {16'h0, mem[66], mem[67]}, {16'h0, tv.mn});
        check({tag, " max_bytes"}, {16'h0, mem[68], mem[69]}, {16'h0, tv.mx});
        check({tag, " indices"}, {12'h0, min_j, min_k, max_j, max_k},
              {12'h0, tv.mnj, tv.mnk, tv.mxj, tv.mxk});
        check({tag, " wr_cnt"}, wr_cnt, 4);
        check({tag, " bad_wr"}, bad_wr, 0);
    endtask

    // Full run: start low, wait for done, optionally hold, then release
    task automatic run_vec(input vec_t tv, input string tag, input int hold);
        int cyc;
        int wr_snap;
        load_mem(tv);
        @(negedge clk); start = 1'b0;
        wait_done(cyc);
        check({tag, " latency"}, cyc, 565);
        check_results(tv, tag);
        if (hold > 0) begin
            int low_cnt = 0;
            wr_snap = wr_cnt;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk); #1;
                if (done && !mem_wen) low_cnt++;
            end
            check({tag, " hold_done"}, low_cnt, hold);
            check({tag, " hold_nowr"}, wr_cnt, wr_snap);
        end
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1;
        check({tag, " done_drop"}, {31'h0, done}, 32'h0);
    endtask

    initial begin
        int cyc;
        reset = 1'b1;
        start = 1'b1;
        wr_cnt = 0;
        bad_wr = 0;
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;

        // Vector table: hand-derived cases, then randomized ones scored by the model
        for (int i = 0; i < 32; i++) tbl[0].vals[i] = 16'h0000;
        tbl[0].mn = 16'h0000; tbl[0].mx = 16'h0000;
        tbl[0].mnj = 5'd0; tbl[0].mnk = 5'd1; tbl[0].mxj = 5'd0; tbl[0].mxk = 5'd0;

        for (int i = 0; i < 32; i++) tbl[1].vals[i] = 16'(100 * i);
        tbl[1].mn = 16'd100; tbl[1].mx = 16'd3100;
        tbl[1].mnj = 5'd0; tbl[1].mnk = 5'd1; tbl[1].mxj = 5'd0; tbl[1].mxk = 5'd31;

        for (int i = 0; i < 32; i++) tbl[2].vals[i] = 16'h0000;
        tbl[2].vals[0] = 16'h8000; tbl[2].vals[1] = 16'h7FFF;
        tbl[2].mn = 16'h0000; tbl[2].mx = 16'hFFFF;
        tbl[2].mnj = 5'd2; tbl[2].mnk = 5'd3; tbl[2].mxj = 5'd0; tbl[2].mxk = 5'd1;

        for (int t = 3; t < NVEC; t++) begin
            for (int i = 0; i < 32; i++) begin
                if (t < 6) tbl[t].vals[i] = 16'($urandom);
                else       tbl[t].vals[i] = 16'($urandom_range(0, 40)) - 16'd20;
            end
            model(tbl[t].vals, tbl[t].mn, tbl[t].mx, tbl[t].mnj, tbl[t].mnk,
                  tbl[t].mxj, tbl[t].mxk);
        end

        repeat (3) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        #1;
        check("reset done", {31'h0, done}, 32'h0);
        check("reset mem_wen", {31'h0, mem_wen}, 32'h0);
        check("reset mem_addr", {24'h0, mem_addr}, 32'h0);
        check("reset mem_wdata", {24'h0, mem_wdata}, 32'h0);
        check("reset indices", {12'h0, min_j, min_k, max_j, max_k}, 32'h0);

        for (int t = 0; t < NVEC; t++)
            run_vec(tbl[t], $sformatf("vec%0d", t), 0);

        // Reset pulsed mid-run: no writes, idle afterwards, then a clean rerun
        load_mem(tbl[3]);
        @(negedge clk); start = 1'b0;
        repeat (300) @(posedge clk);
        @(negedge clk); reset = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        check("midreset done", {31'h0, done}, 32'h0);
        check("midreset mem_wen", {31'h0, mem_wen}, 32'h0);
        check("midreset mem_addr", {24'h0, mem_addr}, 32'h0);
        @(negedge clk); reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("midreset idle done", {31'h0, done}, 32'h0);
        check("midreset no writes", wr_cnt, 0);
        run_vec(tbl[3], "rerun", 0);

        // Start held low after done, then a second run with identical results
        run_vec(tbl[1], "hold", 20);
        load_mem(tbl[1]);
        @(negedge clk); start = 1'b0;
        wait_done(cyc);
        check("second latency", cyc, 565);
        check_results(tbl[1], "second");
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1;
        check("second done_drop", {31'h0, done}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
